prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader_word_assembler.sv | 36 +++
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Frame: A5, D_CNT(LE16), I_CNT(LE16), data words, instruction words, XOR checksum.
package prog_loader_pkg;

  localparam int         DATA_WIDTH       = 32;
  localparam logic [7:0] LOADER_MAGIC     = 8'hA5;
  localparam int         LOADER_MAX_WORDS = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_INSTR = 3'd3,
    ST_CSUM  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // States in which the loader keeps accepting bytes.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_DATA) ||
           (s == ST_INSTR) || (s == ST_CSUM);
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_INSTR) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four bytes LSB-first into a 32-bit word; word_valid marks the 4th byte
// combinationally so the top can register the write port one cycle later.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shreg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt <= 2'd0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld) begin
      shreg <= {byte_dat, shreg[23:8]};
    end
  end

  // The three earlier bytes sit in shreg, oldest in the low byte.
  assign word_valid = byte_vld && (byte_cnt == 2'd3);
  assign word       = {byte_dat, shreg};

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses the framed byte stream, writes data/instruction BRAMs and
// releases the core once the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = LOADER_MAX_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_dat,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  pc_stall,
  output logic                  i_r_enb,
  output logic                  rd_enbl,
  output logic                  d_bram_init_done,
  output logic                  busy,
  output logic                  err
);

  localparam int          IDX_W   = $clog2(MAX_WORDS) + 1;
  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    byte_vld;
  logic                    asm_clr;
  logic                    word_valid;
  logic [DATA_WIDTH-1:0]   word;
  logic [15:0]             hdr_d;
  logic [15:0]             hdr_i;
  logic                    hdr_bad;
  logic [IDX_W-1:0]        word_idx;
  logic [IDX_W-1:0]        d_cnt;
  logic [IDX_W-1:0]        i_cnt;
  logic [IDX_W-1:0]        cur_cnt;
  logic                    last_word;
  logic [7:0]              csum;
  logic [ADDR_WIDTH-1:0]   word_addr;

  assign accept   = rx_valid && rx_ready;
  assign byte_vld = accept && ((state == ST_HDR) || (state == ST_DATA) ||
                               (state == ST_INSTR));
  assign asm_clr  = accept && (state == ST_IDLE) && (rx_dat == LOADER_MAGIC);

  // The header is itself one little-endian word: {I_CNT, D_CNT}.
  assign hdr_d   = word[15:0];
  assign hdr_i   = word[31:16];
  assign hdr_bad = (hdr_d > MAX_CNT) || (hdr_i > MAX_CNT);

  assign cur_cnt   = (state == ST_INSTR) ? i_cnt : d_cnt;
  assign last_word = (word_idx + IDX_W'(1)) == cur_cnt;
  assign word_addr = ADDR_WIDTH'({word_idx, 2'b00});

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_vld  (byte_vld),
    .byte_dat  (rx_dat),
    .word_valid(word_valid),
    .word      (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (asm_clr) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (word_valid) begin
          if (hdr_bad)             state_nxt = ST_ERR;
          else if (hdr_d != 16'd0) state_nxt = ST_DATA;
          else if (hdr_i != 16'd0) state_nxt = ST_INSTR;
          else                     state_nxt = ST_CSUM;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word)
          state_nxt = (i_cnt != '0) ? ST_INSTR : ST_CSUM;
      end
      ST_INSTR: begin
        if (word_valid && last_word) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        if (accept) state_nxt = (rx_dat == csum) ? ST_RUN : ST_ERR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      rx_ready         <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      d_bram_init_done <= 1'b0;
      i_w_enb          <= 1'b0;
      d_w_enb          <= 1'b0;
      i_w_addr         <= '0;
      d_w_addr         <= '0;
      i_w_dat          <= '0;
      d_w_dat          <= '0;
      word_idx         <= '0;
      csum             <= 8'd0;
    end else begin
      state            <= state_nxt;
      rx_ready         <= is_rx_state(state_nxt);
      busy             <= is_busy_state(state_nxt);
      err              <= (state_nxt == ST_ERR);
      pc_stall         <= (state_nxt != ST_RUN);
      i_r_enb          <= (state_nxt == ST_RUN);
      rd_enbl          <= (state_nxt == ST_RUN);
      d_bram_init_done <= (state_nxt == ST_RUN);
      d_w_enb          <= word_valid && (state == ST_DATA);
      i_w_enb          <= word_valid && (state == ST_INSTR);

      if (asm_clr)       csum <= 8'd0;
      else if (byte_vld) csum <= csum ^ rx_dat;

      if (word_valid) begin
        case (state)
          ST_HDR: word_idx <= '0;
          ST_DATA: begin
            d_w_addr <= word_addr;
            d_w_dat  <= word;
            word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
          end
          ST_INSTR: begin
            i_w_addr <= word_addr;
            i_w_dat  <= word;
            word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
          end
          default: word_idx <= word_idx;
        endcase
      end
    end
  end

  // Image sizes are only meaningful after a header that passed the limit check.
  always_ff @(posedge clk) begin
    if ((state == ST_HDR) && word_valid) begin
      d_cnt <= hdr_d[IDX_W-1:0];
      i_cnt <= hdr_i[IDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected BRAM writes are queued as bytes are
// driven and retired by a write-port monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_dat = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic        pc_stall, i_r_enb, rd_enbl, d_bram_init_done, busy, err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(10), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .pc_stall(pc_stall), .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
    .d_bram_init_done(d_bram_init_done), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        is_i;
    logic [9:0]  addr;
    logic [31:0] dat;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] dq[$];
  logic [31:0] iq[$];
  int          total = 0;
  int          bad = 0;
  int          sent;
  int          limit;
  bit          gap_mode;
  logic [7:0]  cs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input logic is_i, input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    if (sb.size() == 0) begin
      chk(is_i ? "extra_i_write" : "extra_d_write", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk(is_i ? "i_write" : "d_write", 64'({is_i, a, d}), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (d_w_enb) check_wr(1'b0, d_w_addr, d_w_dat);
    if (i_w_enb) check_wr(1'b1, i_w_addr, i_w_dat);
  end

  function automatic bit will_send();
    return (limit < 0) || (sent < limit);
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    rx_dat   = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      acc = rx_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) chk("rx_accept_timeout", 64'(rx_ready), 64'd1);
  endtask

  task automatic tx(input logic [7:0] b);
    if (!will_send()) return;
    send_byte(b);
    sent++;
    if (gap_mode) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic is_i, input int idx, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && will_send()) sb.push_back({is_i, 10'(idx * 4), w});
      cs = cs ^ w[8*k +: 8];
      tx(w[8*k +: 8]);
    end
  endtask

  task automatic send_frame(input logic [15:0] dc, input logic [15:0] ic, input bit flip,
                            input bit gaps, input int lim, input bit garbage);
    sent = 0;
    limit = lim;
    gap_mode = gaps;
    if (garbage) begin
      tx(8'h00); tx(8'hFF); tx(8'h5A);
    end
    tx(8'hA5);
    cs = dc[7:0] ^ dc[15:8] ^ ic[7:0] ^ ic[15:8];
    tx(dc[7:0]); tx(dc[15:8]); tx(ic[7:0]); tx(ic[15:8]);
    if (dc <= 16'd256 && ic <= 16'd256) begin
      for (int i = 0; i < int'(dc); i++) send_word(1'b0, i, dq[i]);
      for (int i = 0; i < int'(ic); i++) send_word(1'b1, i, iq[i]);
    end
    if (will_send()) chk("pre_csum_state", 64'({busy, pc_stall, d_bram_init_done}), 64'b110);
    tx(cs ^ {7'd0, flip});
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({rx_ready, busy, err, i_w_enb, d_w_enb, pc_stall, i_r_enb, rd_enbl,
                         d_bram_init_done}), 64'b000001000);
    chk("rst_addr", 64'({i_w_addr, d_w_addr}), 64'd0);
    chk("rst_dat", {i_w_dat, d_w_dat}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_rst", 64'(rx_ready), 64'd1);
  endtask

  task automatic check_run(input string tag);
    chk(tag, 64'({rx_ready, busy, err, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}),
        64'b0000111);
  endtask

  task automatic check_err(input string tag);
    chk(tag, 64'({rx_ready, busy, err, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}),
        64'b0011000);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    dq = '{32'h0000002A, 32'h00000002, 32'hFFFFFFD6};
    iq = '{32'h00000013, 32'h00100093, 32'h00208113, 32'hFFF00193,
           32'h12345237, 32'h0041A023, 32'hDEADBEEF, 32'h0000006F};

    @(negedge clk);
    do_reset();

    // Nominal frame, back-to-back bytes.
    send_frame(16'd3, 16'd8, 1'b0, 1'b0, -1, 1'b0);
    check_run("run_after_csum");
    drain("sb_empty_good");
    check_run("run_holds");

    // Corrupted checksum: all writes still happen, then error.
    do_reset();
    send_frame(16'd3, 16'd8, 1'b1, 1'b0, -1, 1'b0);
    check_err("err_bad_csum");
    drain("sb_empty_bad_csum");
    check_err("err_holds");

    // Leading garbage and rx_valid toggling every other cycle.
    do_reset();
    send_frame(16'd3, 16'd8, 1'b0, 1'b1, -1, 1'b1);
    check_run("run_gaps");
    drain("sb_empty_gaps");

    // Empty images.
    do_reset();
    send_frame(16'd0, 16'd0, 1'b0, 1'b0, -1, 1'b0);
    check_run("run_empty");
    drain("sb_empty_empty");

    // Oversized instruction count: error right after the header.
    do_reset();
    send_frame(16'd0, 16'h0101, 1'b0, 1'b0, 5, 1'b0);
    check_err("err_hdr");
    drain("sb_empty_hdr");
    do_reset();
    send_frame(16'd3, 16'd8, 1'b0, 1'b0, -1, 1'b0);
    check_run("run_after_hdr_err");
    drain("sb_empty_after_hdr");

    // Reset two bytes into the second data word.
    do_reset();
    send_frame(16'd3, 16'd8, 1'b0, 1'b0, 11, 1'b0);
    chk("busy_mid_frame", 64'({busy, pc_stall}), 64'b11);
    do_reset();
    drain("sb_empty_mid_rst");
    send_frame(16'd3, 16'd8, 1'b0, 1'b0, -1, 1'b0);
    check_run("run_after_mid_rst");
    drain("sb_empty_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
